// File: rtl/mvm_sequencer.sv
// mvm_sequencer: control sequencer for the matrix-vector multiply datapath.
// Reads ROWS matrix words plus one vector word over an Avalon-MM style read
// port, unpacks each word MSB byte first into the per-row FIFOs, then runs
// the MAC array for COLS cycles, waits DRAIN cycles and reports done.
// Optional: define MVM_SEQ_PERF_CNT_EN to add the perf_cycles busy counter.
module mvm_sequencer #(
   parameter int unsigned       ROWS      = 8,
   parameter int unsigned       COLS      = 8,
   parameter int unsigned       DW        = 8,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       DRAIN     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    mem_address,
   output logic                 mem_read,
   input  logic [COLS*DW-1:0]   mem_readdata,
   input  logic                 mem_readdatavalid,
   input  logic                 mem_waitrequest,
   output logic [ROWS:0]        fifo_wr_en,
   output logic [DW-1:0]        fifo_wdata,
   input  logic [ROWS:0]        fifo_full,
   output logic                 fifo_rd_en,
   output logic                 mac_en,
   output logic                 mac_clr
`ifdef MVM_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]          perf_cycles
`endif
);

   localparam int unsigned RW = $clog2(ROWS + 1);
   localparam int unsigned BW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [BW-1:0] LastByte = BW'(COLS - 1);
   localparam logic [CW-1:0] LastDrain = CW'(DRAIN - 1);

   typedef enum logic [2:0] {
      StIdle, StFillBuf, StFillFifo, StCalc, StWait, StDone
   } state_t;

   state_t                state;
   logic [RW-1:0]         row;
   logic [RW-1:0]         row_inc;
   logic [BW-1:0]         byte_cnt;
   logic [CW-1:0]         drain_cnt;
   logic [COLS*DW-1:0]    word_buf;
   logic                  accepted;
   logic                  accept_now;
   logic                  data_ok;

   assign row_inc    = row + 1'b1;
   assign accept_now = mem_read && !mem_waitrequest;
   // Valid only counts once our single request has been (or is being) accepted
   assign data_ok    = mem_readdatavalid && (accepted || accept_now);

   // Sequencer FSM with registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         row         <= '0;
         byte_cnt    <= '0;
         drain_cnt   <= '0;
         word_buf    <= '0;
         accepted    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_read    <= 1'b0;
         mem_address <= '0;
         fifo_rd_en  <= 1'b0;
         mac_en      <= 1'b0;
         mac_clr     <= 1'b0;
      end else begin
         mac_clr <= 1'b0;
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state       <= StFillBuf;
                  row         <= '0;
                  accepted    <= 1'b0;
                  mac_clr     <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  mem_read    <= 1'b1;
                  mem_address <= BASE_ADDR;
               end
            end
            StFillBuf: begin
               if (accept_now) begin
                  mem_read <= 1'b0;
                  accepted <= 1'b1;
               end
               if (data_ok) begin
                  word_buf <= mem_readdata;
                  byte_cnt <= '0;
                  accepted <= 1'b0;
                  state    <= StFillFifo;
               end
            end
            StFillFifo: begin
               // The top byte of word_buf is always the next byte to push
               if (!fifo_full[row]) begin
                  word_buf <= word_buf << DW;
                  if (byte_cnt == LastByte) begin
                     byte_cnt <= '0;
                     if (row == RW'(ROWS)) begin
                        state      <= StCalc;
                        fifo_rd_en <= 1'b1;
                        mac_en     <= 1'b1;
                     end else begin
                        row         <= row_inc;
                        mem_read    <= 1'b1;
                        mem_address <= BASE_ADDR + ADDR_W'(row_inc);
                        state       <= StFillBuf;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            StCalc: begin
               if (byte_cnt == LastByte) begin
                  byte_cnt   <= '0;
                  drain_cnt  <= '0;
                  fifo_rd_en <= 1'b0;
                  mac_en     <= 1'b0;
                  if (DRAIN == 0) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= StWait;
                  end
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            StWait: begin
               if (drain_cnt == LastDrain) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // FIFO push is gated by the full flag in the same cycle, so a stall never drops a byte
   always_comb begin
      fifo_wr_en = '0;
      fifo_wdata = '0;
      if (state == StFillFifo) begin
         fifo_wdata      = word_buf[COLS*DW-1 -: DW];
         fifo_wr_en[row] = !fifo_full[row];
      end
   end

`ifdef MVM_SEQ_PERF_CNT_EN
   // Busy-cycle counter: cleared on start accept, saturating, frozen once busy drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
      end else if ((state == StIdle || state == StDone) && start) begin
         perf_cycles <= '0;
      end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`else
   // No performance counter in this build
`endif

endmodule

// File: tb/tb_mvm_sequencer.sv
// tb_mvm_sequencer: directed runs with randomized memory contents, checked
// against a reference of what each FIFO must receive, which addresses must be
// read and how long each run must take.
module tb_mvm_sequencer;

   localparam int unsigned ROWS   = 8;
   localparam int unsigned COLS   = 8;
   localparam int unsigned DW     = 8;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DRAIN  = 2;
   localparam int          NRD    = ROWS + 1;
   localparam int          BASE   = NRD * (2 + COLS) + COLS + DRAIN;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                start = 1'b0;
   logic                busy, done, mem_read, fifo_rd_en, mac_en, mac_clr;
   logic [ADDR_W-1:0]   mem_address;
   logic [COLS*DW-1:0]  mem_readdata = '0;
   logic                mem_readdatavalid = 1'b0;
   logic                mem_waitrequest = 1'b0;
   logic [ROWS:0]       fifo_wr_en;
   logic [DW-1:0]       fifo_wdata;
   logic [ROWS:0]       fifo_full = '0;
`ifdef MVM_SEQ_PERF_CNT_EN
   logic [31:0]         perf_cycles;
`endif

   always #5 clk = ~clk;

   mvm_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .DW(DW), .ADDR_W(ADDR_W), .BASE_ADDR(32'd0), .DRAIN(DRAIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
      .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
      .fifo_rd_en(fifo_rd_en), .mac_en(mac_en), .mac_clr(mac_clr)
`ifdef MVM_SEQ_PERF_CNT_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // memory contents and slave model
   logic [63:0] mem [NRD];
   logic        pend = 1'b0;
   int          pend_idx = 0;
   int          ws_addr = -1, ws_left = 0;
   logic        ws_active = 1'b0, stray = 1'b0;
   // fifo_full stall model
   int          full_row = 0, full_after = 0, full_len = 0, full_left = 0;
   logic        full_armed = 1'b0;
   // monitors
   logic [ADDR_W-1:0] acc_q[$];
   logic [7:0]        got [NRD][$];
   int mac_cnt, first_mac, last_mac, done_cyc, busy_cnt, clr_cnt;
   int bad_push, bad_hot, bad_rd;
   logic prev_done = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive slave responses after the edge, then sample outputs
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      mem_waitrequest   = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata      = {$urandom, $urandom};
      fifo_full         = '0;
      if (pend) begin
         mem_readdatavalid = 1'b1;
         mem_readdata = (pend_idx >= 0 && pend_idx < NRD) ? mem[pend_idx] : 64'hBAD0_BAD0_BAD0_BAD0;
         pend = 1'b0;
      end else if (ws_active) begin
         mem_waitrequest = 1'b1;
         check("wait_read_held", mem_read, 1);
         check("wait_addr_held", mem_address, ws_addr);
         ws_left--;
         if (ws_left == 0) ws_active = 1'b0;
      end else if (ws_left > 0 && mem_read && int'(mem_address) == ws_addr) begin
         mem_waitrequest = 1'b1;
         ws_left--;
         ws_active = (ws_left > 0);
      end
      if (mem_waitrequest && stray) begin
         mem_readdatavalid = 1'b1;
         mem_readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (full_left > 0) begin
         fifo_full[full_row] = 1'b1;
         full_left--;
      end
      #1;
      if (mem_read && !mem_waitrequest) begin
         acc_q.push_back(mem_address);
         pend = 1'b1;
         pend_idx = int'(mem_address);
      end
      if ($countones(fifo_wr_en) > 1) bad_hot++;
      for (int r = 0; r < NRD; r++) begin
         if (fifo_wr_en[r]) begin
            if (fifo_full[r]) bad_push++;
            got[r].push_back(fifo_wdata);
         end
      end
      if (full_armed && got[full_row].size() == full_after) begin
         full_left  = full_len;
         full_armed = 1'b0;
      end
      if (mac_en) begin
         if (mac_cnt == 0) first_mac = cyc;
         last_mac = cyc;
         mac_cnt++;
      end
      if (fifo_rd_en !== mac_en) bad_rd++;
      if (busy) busy_cnt++;
      if (mac_clr) clr_cnt++;
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
   endtask

   task automatic clear_mon();
      acc_q.delete();
      for (int r = 0; r < NRD; r++) got[r].delete();
      mac_cnt = 0; first_mac = 0; last_mac = 0; done_cyc = -1000;
      busy_cnt = 0; clr_cnt = 0; bad_push = 0; bad_hot = 0; bad_rd = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_mem_read"}, mem_read, 0);
      check({tag, "_mem_address"}, mem_address, 0);
      check({tag, "_fifo_wr_en"}, fifo_wr_en, 0);
      check({tag, "_fifo_wdata"}, fifo_wdata, 0);
      check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
      check({tag, "_mac_en"}, mac_en, 0);
      check({tag, "_mac_clr"}, mac_clr, 0);
   endtask

   // One full run: start pulse, bounded wait for done, then the end-of-run checks
   task automatic do_run(input string tag, input int exp_busy, input logic poke);
      logic [63:0] w;
      clear_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_start_busy"}, busy, 1);
      check({tag, "_start_done_drop"}, done, 0);
`ifdef MVM_SEQ_PERF_CNT_EN
      check({tag, "_perf_cleared"}, perf_cycles, 0);
`endif
      for (int i = 0; i < 1000 && !done; i++) begin
         start = poke && (i >= 20) && (i < 23);
         tick();
      end
      start = 1'b0;
      check({tag, "_done_reached"}, done, 1);
      check({tag, "_busy_in_done"}, busy, 0);
      check({tag, "_read_count"}, acc_q.size(), NRD);
      for (int i = 0; i < NRD; i++)
         check({tag, "_addr"}, (i < acc_q.size()) ? acc_q[i] : 'x, i);
      for (int r = 0; r < NRD; r++) begin
         w = '0;
         for (int k = 0; k < got[r].size(); k++) w = {w[55:0], got[r][k]};
         check({tag, "_push_count"}, got[r].size(), COLS);
         check({tag, "_fifo_bytes"}, w, mem[r]);
      end
      check({tag, "_mac_cycles"}, mac_cnt, COLS);
      check({tag, "_mac_consecutive"}, last_mac - first_mac, COLS - 1);
      check({tag, "_done_after_mac"}, done_cyc - last_mac, DRAIN + 1);
      check({tag, "_push_while_full"}, bad_push, 0);
      check({tag, "_push_onehot"}, bad_hot, 0);
      check({tag, "_rd_en_align"}, bad_rd, 0);
      check({tag, "_mac_clr_pulses"}, clr_cnt, 1);
      check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
`ifdef MVM_SEQ_PERF_CNT_EN
      check({tag, "_perf_cycles"}, perf_cycles, exp_busy);
`endif
   endtask

   initial begin
      logic [63:0] w;
      // reset state
      #2 rst_n = 1'b0;
      tick();
      tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      tick();
      check("idle_after_reset_busy", busy, 0);

      // run 1: zero-wait memory, row r holds r+1 in every byte
      for (int r = 0; r < NRD; r++) begin
         w = '0;
         for (int k = 0; k < COLS; k++) w = {w[55:0], 8'(r + 1)};
         mem[r] = w;
      end
      do_run("zw", BASE, 1'b0);

      // run 2: byte order, 5-cycle waitrequest on read 3 with a stray valid
      mem[0] = 64'h0102_0304_0506_0708;
      for (int r = 1; r < NRD; r++) mem[r] = {$urandom, $urandom};
      ws_addr = 3; ws_left = 5; stray = 1'b1;
      do_run("ws", BASE + 5, 1'b0);
      check("ws_first_byte", (got[0].size() > 0) ? got[0][0] : 'x, 8'h01);
      check("ws_last_byte", (got[0].size() == COLS) ? got[0][COLS-1] : 'x, 8'h08);
      stray = 1'b0; ws_addr = -1;

      // run 3: fifo_full[2] high 4 cycles after 3 bytes, start poked mid-run
      for (int r = 0; r < NRD; r++) mem[r] = {$urandom, $urandom};
      full_row = 2; full_after = 3; full_len = 4; full_armed = 1'b1;
      do_run("st", BASE + 4, 1'b1);
      check("st_stall_armed_used", full_armed, 0);

      // run 4: async reset in the middle of CALC
      clear_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 1000 && mac_cnt < 3; i++) tick();
      check("calc_reached", mac_cnt, 3);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      pend = 1'b0;
      tick();
      check_outputs_zero("midrst_held");
`ifdef MVM_SEQ_PERF_CNT_EN
      check("midrst_perf", perf_cycles, 0);
`endif
      rst_n = 1'b1;
      tick();
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_idle_done", done, 0);

      // run 5: clean run after the abort
      for (int r = 0; r < NRD; r++) mem[r] = {$urandom, $urandom};
      do_run("clean", BASE, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
